// File: rtl/alu_pipe.sv
// Pipelined EX-stage ALU with valid/ready handshakes, NZCV flags and a tag per operation.
// Single-cycle ops load the output register on acceptance; MUL runs an iterative shift-add over WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_LSL  = 4'b0110;
  localparam logic [3:0] OP_LSR  = 4'b0111;
  localparam logic [3:0] OP_ASR  = 4'b1000;
  localparam logic [3:0] OP_EQ   = 4'b1001;
  localparam logic [3:0] OP_LT   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, WAIT} state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc, a_sh, mul_sum, mul_result;
  logic [WIDTH-1:0]   b_sh;
  logic [SHW-1:0]     cnt;
  logic [TAG_W-1:0]   mul_tag;
  logic               out_free, last_iter, accept, load_single, load_mul;

  logic [WIDTH:0]     sum, diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_z;
  logic [3:0]         alu_flags, mul_flags;
  logic               alu_c, alu_v, flag_en;

  assign out_free  = ~out_valid | out_ready;
  assign last_iter = (cnt == SHW'(WIDTH - 1));
  assign mul_sum   = acc + (b_sh[0] ? a_sh : '0);
  assign shamt     = in_b[SHW-1:0];

  always_comb begin
    alu_z   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    flag_en = 1'b1;
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    case (in_op)
      OP_ADD: begin
        alu_z = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      // C is the inverted borrow, i.e. set when A >= B unsigned
      OP_SUB: begin
        alu_z = diff[WIDTH-1:0];
        alu_c = ~diff[WIDTH];
        alu_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_z = in_a & in_b;
      OP_OR:   alu_z = in_a | in_b;
      OP_XOR:  alu_z = in_a ^ in_b;
      OP_XNOR: alu_z = ~(in_a ^ in_b);
      OP_LSL:  alu_z = in_a << shamt;
      OP_LSR:  alu_z = in_a >> shamt;
      OP_ASR:  alu_z = $unsigned($signed(in_a) >>> shamt);
      OP_EQ:   alu_z = {{(WIDTH-1){1'b0}}, in_a == in_b};
      OP_LT:   alu_z = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_GT:   alu_z = {{(WIDTH-1){1'b0}}, $signed(in_a) > $signed(in_b)};
      default: flag_en = 1'b0;
    endcase
    alu_flags = flag_en ? {alu_z[WIDTH-1], alu_z == '0, alu_c, alu_v} : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && in_op == OP_MUL) state_next = MUL;
      MUL:     if (last_iter) state_next = out_free ? IDLE : WAIT;
      WAIT:    if (out_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // On the final iteration the product is taken straight from the adder; in WAIT it already sits in acc
  always_comb begin
    in_ready    = (state == IDLE) & out_free;
    accept      = in_valid & in_ready;
    load_single = accept & (in_op != OP_MUL);
    load_mul    = ((state == MUL) & last_iter & out_free) | ((state == WAIT) & out_free);
    mul_result  = (state == WAIT) ? acc : mul_sum;
    mul_flags   = {mul_result[WIDTH-1], mul_result[WIDTH-1:0] == '0, 1'b0,
                   mul_result[2*WIDTH-1:WIDTH] != '0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      mul_tag   <= '0;
    end else begin
      if (load_single) begin
        out_valid <= 1'b1;
        out_z     <= alu_z;
        out_tag   <= in_tag;
        out_flags <= alu_flags;
      end else if (load_mul) begin
        out_valid <= 1'b1;
        out_z     <= mul_result[WIDTH-1:0];
        out_tag   <= mul_tag;
        out_flags <= mul_flags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && in_op == OP_MUL) begin
        acc     <= '0;
        a_sh    <= {{WIDTH{1'b0}}, in_a};
        b_sh    <= in_b;
        cnt     <= '0;
        mul_tag <= in_tag;
      end else if (state == MUL) begin
        acc  <= mul_sum;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a cycle-level behavioural model checks every output each cycle,
// with directed scenarios, randomized traffic, and a second WIDTH=8 instance for narrow-width cases.
module tb_alu_pipe;

  localparam int W  = 64;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_z;
  logic [3:0]    in_op, out_flags;
  logic [TW-1:0] in_tag, out_tag;

  logic          v8, rdy8, ov8, or8;
  logic [7:0]    a8, b8, z8;
  logic [3:0]    op8, fl8;
  logic [TW-1:0] tag8, tag8o;

  int numChecks = 0;
  int numErrors = 0;
  bit randReady = 1'b0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag), .out_flags(out_flags)
  );

  alu_pipe #(.WIDTH(8), .TAG_W(TW)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8), .in_op(op8), .in_tag(tag8),
    .out_valid(ov8), .out_ready(or8), .out_z(z8), .out_tag(tag8o), .out_flags(fl8)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Reference result {N,Z,C,V, z} computed with wide plain arithmetic
  function automatic logic [67:0] refAlu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0]        z;
    logic               c, v;
    logic [64:0]        wide;
    logic signed [64:0] sa, sb, ss;
    logic [127:0]       p;
    int                 sh;
    z  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sh = int'(b[5:0]);
    sa = $signed({a[63], a});
    sb = $signed({b[63], b});
    case (op)
      4'd0: begin wide = {1'b0, a} + {1'b0, b}; z = wide[63:0]; c = wide[64]; ss = sa + sb; v = (ss[64] != ss[63]); end
      4'd1: begin z = a - b; c = (a >= b); ss = sa - sb; v = (ss[64] != ss[63]); end
      4'd2: z = a & b;
      4'd3: z = a | b;
      4'd4: z = a ^ b;
      4'd5: z = ~(a ^ b);
      4'd6: z = a << sh;
      4'd7: z = a >> sh;
      4'd8: z = $unsigned($signed(a) >>> sh);
      4'd9: z = (a == b) ? 64'd1 : 64'd0;
      4'd10: z = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd11: z = ($signed(a) > $signed(b)) ? 64'd1 : 64'd0;
      4'd12: begin p = {64'd0, a} * {64'd0, b}; z = p[63:0]; v = (p[127:64] != 0); end
      default: return 68'd0;
    endcase
    return {z[63], z == 64'd0, c, v, z};
  endfunction

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Cycle-level model: output register occupancy, in-flight multiply and its completion cycle
  logic          mOutValid = 1'b0, mMulActive = 1'b0;
  logic [63:0]   mZ = '0;
  logic [TW-1:0] mTag = '0, mulTag = '0;
  logic [3:0]    mFlags = '0;
  logic [67:0]   mulRes = '0, r;
  logic          expReady, acc, pop, free, load;
  int            t = 0, mulStart = 0;

  always @(negedge clk) begin
    expReady = !mMulActive && (!mOutValid || out_ready);
    checkOutput("cyc_out_valid", out_valid, mOutValid);
    checkOutput("cyc_in_ready", in_ready, expReady);
    checkOutput("cyc_out_z", out_z, mZ);
    checkOutput("cyc_out_tag", out_tag, mTag);
    checkOutput("cyc_out_flags", out_flags, mFlags);
    acc  = in_valid && expReady;
    pop  = mOutValid && out_ready;
    free = !mOutValid || out_ready;
    load = 1'b0;
    if (rst) begin
      mOutValid = 1'b0; mMulActive = 1'b0; mZ = '0; mTag = '0; mFlags = '0;
    end else begin
      if (acc && in_op != 4'd12) begin
        r = refAlu(in_op, in_a, in_b);
        load = 1'b1; mZ = r[63:0]; mFlags = r[67:64]; mTag = in_tag;
      end else if (mMulActive && (t - mulStart) >= W && free) begin
        load = 1'b1; mZ = mulRes[63:0]; mFlags = mulRes[67:64]; mTag = mulTag; mMulActive = 1'b0;
      end
      if (acc && in_op == 4'd12) begin
        mMulActive = 1'b1; mulStart = t; mulRes = refAlu(in_op, in_a, in_b); mulTag = in_tag;
      end
      if (load)     mOutValid = 1'b1;
      else if (pop) mOutValid = 1'b0;
    end
    t++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [TW-1:0] tag, output int waits);
    bit done;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    waits = 0;
    done = 1'b0;
    while (!done && waits < 200) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      numChecks++; numErrors++;
      $display("[TB] FAIL accept_timeout: actual=no accept required=accept within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int waits, cyc;
    logic [67:0] m;
    logic [3:0]  sOp[8];
    logic [63:0] sA[8], sB[8];

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; tag8 = '0; or8 = 1'b1;

    m = refAlu(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    checkOutput("model_add_z", m[63:0], 64'h8000_0000_0000_0000);
    checkOutput("model_add_flags", m[67:64], 4'b1001);
    m = refAlu(4'd1, 64'd5, 64'd5);
    checkOutput("model_sub_flags", m[67:64], 4'b0110);
    m = refAlu(4'd6, 64'd1, 64'h43);
    checkOutput("model_lsl_z", m[63:0], 64'd8);
    m = refAlu(4'd8, 64'h8000_0000_0000_0000, 64'd63);
    checkOutput("model_asr_z", m[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    m = refAlu(4'd12, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    checkOutput("model_mul_z", m[63:0], 64'hFFFF_FFFE_0000_0001);
    m = refAlu(4'd12, 64'h8000_0000_0000_0000, 64'd2);
    checkOutput("model_mul_ovf_flags", m[67:64], 4'b0101);
    m = refAlu(4'd13, 64'd0, 64'd0);
    checkOutput("model_undef_flags", m[67:64], 4'b0000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd1, waits);
    waitValid(cyc);
    checkOutput("add_latency", cyc, 1);
    checkOutput("add_z", out_z, 64'h8000_0000_0000_0000);
    checkOutput("add_flags", out_flags, 4'b1001);
    checkOutput("add_tag", out_tag, 5'd1);
    @(posedge clk); #1;

    applyStimulus(4'd1, 64'd5, 64'd5, 5'd2, waits);
    waitValid(cyc);
    checkOutput("sub_z", out_z, 64'd0);
    checkOutput("sub_flags", out_flags, 4'b0110);
    @(posedge clk); #1;

    sOp[0] = 4'd6;  sA[0] = 64'd1;                   sB[0] = 64'h43;
    sOp[1] = 4'd8;  sA[1] = 64'h8000_0000_0000_0000; sB[1] = 64'd63;
    sOp[2] = 4'd10; sA[2] = '1;                      sB[2] = 64'd0;
    sOp[3] = 4'd11; sA[3] = '1;                      sB[3] = 64'd0;
    sOp[4] = 4'd5;  sA[4] = 64'h1234_5678_9ABC_DEF0; sB[4] = 64'h1234_5678_9ABC_DEF0;
    sOp[5] = 4'd0;  sA[5] = '1;                      sB[5] = 64'd1;
    sOp[6] = 4'd7;  sA[6] = 64'h8000_0000_0000_0000; sB[6] = 64'hFFC0;
    sOp[7] = 4'd9;  sA[7] = 64'd7;                   sB[7] = 64'd7;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(sOp[i], sA[i], sB[i], 5'(10 + i), waits);
      checkOutput("stream_no_stall", waits, 0);
    end
    repeat (2) begin @(posedge clk); #1; end

    applyStimulus(4'd3, 64'hF0, 64'h0F, 5'd20, waits);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd2; in_a = 64'hFF; in_b = 64'h0F; in_tag = 5'd21;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_hold_z", out_z, 64'hFF);
      checkOutput("bp_hold_tag", out_tag, 5'd20);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(4'd2, 64'hFF, 64'h0F, 5'd21, waits);
    checkOutput("bp_pop_accept_same_edge", waits, 0);
    waitValid(cyc);
    checkOutput("bp_next_z", out_z, 64'h0F);
    @(posedge clk); #1;

    applyStimulus(4'd12, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3, waits);
    waitValid(cyc);
    checkOutput("mul_latency", cyc, W + 1);
    checkOutput("mul_z", out_z, 64'hFFFF_FFFE_0000_0001);
    checkOutput("mul_flags", out_flags, 4'b1000);
    checkOutput("mul_tag", out_tag, 5'd3);
    @(posedge clk); #1;

    applyStimulus(4'd12, 64'h8000_0000_0000_0000, 64'd2, 5'd4, waits);
    waitValid(cyc);
    checkOutput("mul_ovf_z", out_z, 64'd0);
    checkOutput("mul_ovf_flags", out_flags, 4'b0101);
    @(posedge clk); #1;

    applyStimulus(4'd12, {$urandom, $urandom}, {$urandom, $urandom}, 5'd7, waits);
    out_ready = 1'b0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    repeat (W + 15) @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    applyStimulus(4'd12, 64'd123, 64'd456, 5'd9, waits);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_mul_valid", out_valid, 0);
    checkOutput("rst_mid_mul_ready", in_ready, 1);
    repeat (W + 10) begin @(posedge clk); #1; end

    v8 = 1'b1; a8 = 8'h80; b8 = 8'h80; op8 = 4'd0; tag8 = 5'd1;
    @(negedge clk);
    checkOutput("w8_in_ready", rdy8, 1);
    @(posedge clk); #1 v8 = 1'b0;
    @(negedge clk);
    checkOutput("w8_add_valid", ov8, 1);
    checkOutput("w8_add_z", z8, 8'h00);
    checkOutput("w8_add_flags", fl8, 4'b0111);
    checkOutput("w8_add_tag", tag8o, 5'd1);
    @(posedge clk); #1;
    v8 = 1'b1; a8 = 8'h10; b8 = 8'h10; op8 = 4'd12; tag8 = 5'd2;
    @(posedge clk); #1 v8 = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!ov8 && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput("w8_mul_latency", cyc, 9);
    checkOutput("w8_mul_z", z8, 8'h00);
    checkOutput("w8_mul_flags", fl8, 4'b0101);
    checkOutput("w8_mul_tag", tag8o, 5'd2);
    @(posedge clk); #1;

    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
          @(posedge clk); #1;
        end
      end
      applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(), 5'($urandom_range(0, 31)), waits);
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    repeat (W + 10) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
